bus_arbiter4: RTL and testbench
===============================

# bus_arbiter4

Round-robin arbiter and sequencer that shares one N-bit datapath, a 4-input select mux, among four requesters. It owns the mux select, grants one requester at a time, and holds the grant across a multi-beat burst until the burst's final beat transfers. It bounds every burst with a beat limit so no requester can starve the others. It sits between the four requesting stages and the single shared downstream consumer.

## Interface
- N, 32, data width of the shared path; the arbiter only routes control, and N sizes the mux it drives.
- MAX_BEATS, 16, maximum beats per grant before forced release; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- req  in  4  per-requester request/valid; bit i high means requester i has a beat ready.
- last  in  4  per-requester final-beat flag; sampled only for the granted requester.
- ready  in  1  downstream accepts a beat this cycle.
- grant  out  4  one-hot grant, registered; 4'b0000 when no grant.
- sel  out  2  binary index of the granted requester, registered; drives the mux select.
- out_valid  out  1  combinational: granted requester's req bit while in GRANT.
- xfer  out  1  combinational: out_valid & ready; one beat moves.
- timeout  out  1  registered one-cycle pulse when MAX_BEATS forces a release.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: grant[g]=1, sel=g.
- Priority pointer ptr (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first requester with req=1 wins.
- IDLE → GRANT: any req bit high. The winner is registered into grant, sel and g.
- GRANT, xfer with last[g]=1: normal release.
  - ptr ← g+1 mod 4; beat_cnt ← 0.
  - In the same cycle, re-arbitrate with the new ptr. If any req is high, stay in GRANT with the new winner (no bubble); otherwise go to IDLE.
  - If g is the only requester, g is re-granted.
- GRANT, xfer with last[g]=0:
  - beat_cnt increments.
  - If beat_cnt reaches MAX_BEATS-1 on this xfer, force a release exactly as for a normal release, and pulse timeout next cycle.
- GRANT, req[g]=0: abort. Release with ptr ← g+1 and re-arbitrate identically. No timeout pulse.
- GRANT, req[g]=1 and ready=0: hold. No state, counter or pointer change.
- Changes on req or last of non-granted requesters never affect an active grant.
- beat_cnt width is $clog2(MAX_BEATS+1). It resets to 0 on every release.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, grant=0000, sel=00, ptr=0, beat_cnt=0, timeout=0.
- Release from reset is synchronous to the next clk edge.
- Grant latency: req rising in cycle t while IDLE → grant/sel valid in cycle t+1. out_valid can rise no earlier than t+1.
- Back-to-back: the final beat in cycle t → the next requester's grant in cycle t+1. Zero idle cycles between bursts.
- out_valid and xfer are combinational from req, ready and the registered state. There are no combinational paths from ready to grant or sel.
- sel and grant change only on clock edges. The mux output is stable for a full cycle.
- timeout is high for exactly one cycle, the cycle after the forced-release edge.
- Reset mid-burst: grant drops immediately (asynchronous). The burst is lost and ptr returns to 0.

## Structure
- A shared package holds:
  - the state enum {IDLE, GRANT};
  - the constant NUM_REQ=4;
  - a function onehot_to_idx (4→2).
- One combinational sub-module, rr_priority_picker: inputs req[3:0] and ptr[1:0]; outputs win_idx[1:0] and any_req.
  - It is used for both the IDLE-state pick and the release-cycle pick.
- Top level contains the state register, grant/sel registers, ptr, beat_cnt and the timeout flop.

## Test plan
- Reset then req=0101, ready=1, last=1111 → cycle 1: grant=0001, sel=00. Next cycle: grant=0100, sel=10. Then back to IDLE with grant=0000.
- All req=1111, single-beat bursts, ready=1 → sel sequence 0,1,2,3,0,… with no idle cycle between grants.
- Requester 2 alone, 5-beat burst, ready toggling 1,0,1,0,… → grant held throughout; xfer only when ready=1; release on the 5th xfer; ptr=3 afterward.
- MAX_BEATS=4, requester 1 with last never set, req=0011 → forced release after 4 xfers; timeout pulses one cycle; next grant=0001 (requester 0).
- Granted requester 3 drops req mid-burst with req=1000→0010 → release in that cycle; grant=0010 next cycle; timeout stays 0.
- rst asserted low mid-burst → grant=0000 and sel=00 immediately. After release, req=1111 → first grant=0001.

Source files
------------

// File: rtl/bus_arbiter4_pkg.sv
// bus_arbiter4_pkg
// Shared types and helpers for the four-way round-robin bus arbiter.
//   state_t        : arbiter state (IDLE / GRANT)
//   NUM_REQ        : number of requesters sharing the datapath
//   onehot_to_idx  : converts a 4-bit one-hot grant into a 2-bit index
package bus_arbiter4_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;

    // Non-one-hot inputs map to index 0; the grant register is only ever
    // loaded with a single set bit or all zeros.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter4_picker.sv
// rr_priority_picker
// Combinational round-robin pick: searches req starting at ptr and wrapping
// modulo 4; the first requester found wins.
//   req     in  4  request vector
//   ptr     in  2  highest-priority index for this pick
//   win_idx out 2  index of the winning requester (0 when none)
//   any_req out 1  at least one request is present
module rr_priority_picker
    import bus_arbiter4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win_idx,
    output logic       any_req
);

    logic [1:0] idx_s;

    // Scan from the lowest priority offset to the highest so the nearest
    // requester to ptr is the last to overwrite the result.
    always_comb begin
        win_idx = 2'd0;
        any_req = 1'b0;
        idx_s   = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = ptr + k[1:0];
            if (req[idx_s]) begin
                win_idx = idx_s;
                any_req = 1'b1;
            end else begin
                win_idx = win_idx;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4
// Round-robin arbiter/sequencer for a shared N-bit datapath with four
// requesters. Holds a grant for a whole burst, releases on the final beat,
// on a dropped request, or after MAX_BEATS beats (with a timeout pulse).
//   clk       in  1  rising-edge clock
//   rst       in  1  asynchronous active-low reset
//   req       in  4  per-requester valid
//   last      in  4  per-requester final-beat flag
//   ready     in  1  downstream accepts a beat
//   grant     out 4  registered one-hot grant
//   sel       out 2  registered mux select (granted index)
//   out_valid out 1  granted requester's req while in GRANT
//   xfer      out 1  out_valid & ready
//   timeout   out 1  registered one-cycle pulse on forced release
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       xfer,
    output logic       timeout
);

    localparam int             CW        = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0]  BEAT_LAST = CW'(MAX_BEATS - 1);

    // Reject parameter values outside the supported range at elaboration.
    if (N < 1 || MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_param_check
        $error("bus_arbiter4: illegal N or MAX_BEATS");
    end

    state_t        state_r;
    logic [3:0]    grant_r;
    logic [1:0]    sel_r;
    logic [1:0]    ptr_r;
    logic [CW-1:0] beat_cnt_r;
    logic          timeout_r;

    logic [1:0]    g_s;
    logic          in_grant_s;
    logic          out_valid_s;
    logic          xfer_s;
    logic          release_s;
    logic          forced_s;
    logic [1:0]    pick_ptr_s;
    logic [1:0]    win_s;
    logic          any_s;

    assign g_s         = onehot_to_idx(grant_r);
    assign in_grant_s  = (state_r == GRANT);
    assign out_valid_s = in_grant_s & req[g_s];
    assign xfer_s      = out_valid_s & ready;

    // While granted, the picker already looks from g+1 so a release can hand
    // the grant straight to the next requester in the same cycle.
    assign pick_ptr_s  = in_grant_s ? (g_s + 2'd1) : ptr_r;

    rr_priority_picker u_picker (
        .req     (req),
        .ptr     (pick_ptr_s),
        .win_idx (win_s),
        .any_req (any_s)
    );

    // Release decision for the active grant: abort, final beat, or beat limit.
    always_comb begin
        release_s = 1'b0;
        forced_s  = 1'b0;
        if (in_grant_s) begin
            if (!req[g_s]) begin
                release_s = 1'b1;
            end else if (xfer_s) begin
                if (last[g_s]) begin
                    release_s = 1'b1;
                end else if (beat_cnt_r == BEAT_LAST) begin
                    release_s = 1'b1;
                    forced_s  = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end else begin
                release_s = 1'b0;
            end
        end else begin
            release_s = 1'b0;
        end
    end

    // Arbiter state, grant/select, priority pointer, beat counter and timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            grant_r    <= 4'b0000;
            sel_r      <= 2'd0;
            ptr_r      <= 2'd0;
            beat_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= forced_s;
            case (state_r)
                IDLE: begin
                    beat_cnt_r <= '0;
                    if (any_s) begin
                        state_r <= GRANT;
                        grant_r <= 4'b0001 << win_s;
                        sel_r   <= win_s;
                    end else begin
                        grant_r <= 4'b0000;
                        sel_r   <= 2'd0;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        ptr_r      <= g_s + 2'd1;
                        beat_cnt_r <= '0;
                        if (any_s) begin
                            grant_r <= 4'b0001 << win_s;
                            sel_r   <= win_s;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 4'b0000;
                            sel_r   <= 2'd0;
                        end
                    end else if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + CW'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    grant_r    <= 4'b0000;
                    sel_r      <= 2'd0;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign sel       = sel_r;
    assign out_valid = out_valid_s;
    assign xfer      = xfer_s;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_bus_arbiter4.sv
module tb_bus_arbiter4;

    localparam int MB = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic       xfer;
    logic       timeout;

    always #5 clk = ~clk;

    bus_arbiter4 #(.N(32), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .ready     (ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .xfer      (xfer),
        .timeout   (timeout)
    );

    typedef struct {
        bit         ov;
        bit         xf;
        logic [3:0] g;
        logic [1:0] s;
        bit         to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the bus, where the search starts, beats moved.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts this cycle's
    // combinational outputs and the registered outputs after the next edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rd, output bit xf_o);
        exp_t e;
        bit   rel;
        bit   forced;
        @(posedge clk);
        #2;
        req   = r;
        last  = l;
        ready = rd;
        e.ov   = (m_owner >= 0) && (r[m_owner] == 1'b1);
        e.xf   = e.ov && rd;
        rel    = 1'b0;
        forced = 1'b0;
        if (m_owner >= 0) begin
            if (r[m_owner] == 1'b0) begin
                rel = 1'b1;
            end else if (e.xf) begin
                m_beats++;
                if (l[m_owner] == 1'b1) rel = 1'b1;
                else if (m_beats == MB) begin
                    rel    = 1'b1;
                    forced = 1'b1;
                end
            end
        end
        if (rel) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_beats = 0;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4] == 1'b1) begin
                    m_owner = (m_ptr + k) % 4;
                    m_beats = 0;
                    break;
                end
            end
        end
        e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.s  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.to = forced;
        q.push_back(e);
        xf_o = e.xf;
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                chk("out_valid", 8'(out_valid), 8'(q[0].ov));
                chk("xfer", 8'(xfer), 8'(q[0].xf));
            end
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", 8'(grant), 8'(e.g));
                chk("sel", 8'(sel), 8'(e.s));
                chk("timeout", 8'(timeout), 8'(e.to));
            end
        end
    end

    initial begin : stim
        bit         xf;
        int         n;
        logic [3:0] rr;
        rst   = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_sel", 8'(sel), 8'h00);
        chk("rst_timeout", 8'(timeout), 8'h00);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        rst = 1'b1;

        // Two requesters, single-beat bursts, then idle.
        cyc(4'b0101, 4'b1111, 1'b1, xf);
        cyc(4'b0101, 4'b1111, 1'b1, xf);
        cyc(4'b0000, 4'b1111, 1'b1, xf);
        cyc(4'b0000, 4'b1111, 1'b1, xf);

        // All requesting, single beats: rotating grants with no bubble.
        for (int i = 0; i < 10; i++) cyc(4'b1111, 4'b1111, 1'b1, xf);
        cyc(4'b0000, 4'b0000, 1'b0, xf);

        // Requester 2 alone, 5-beat burst, ready toggling.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(4'b0100, (n == 4) ? 4'b0100 : 4'b0000, (i % 2 == 0) ? 1'b1 : 1'b0, xf);
            if (xf) n++;
            if (n == 5) break;
        end
        cyc(4'b0000, 4'b0000, 1'b1, xf);
        cyc(4'b1111, 4'b1111, 1'b1, xf);
        cyc(4'b0000, 4'b0000, 1'b0, xf);

        // Two requesters never asserting last: beat limit forces releases.
        for (int i = 0; i < 16; i++) cyc(4'b0011, 4'b0000, 1'b1, xf);
        cyc(4'b0000, 4'b0000, 1'b0, xf);

        // Requester 3 drops its request mid-burst.
        cyc(4'b1000, 4'b0000, 1'b1, xf);
        cyc(4'b1000, 4'b0000, 1'b1, xf);
        cyc(4'b0010, 4'b0000, 1'b1, xf);
        cyc(4'b0010, 4'b0000, 1'b0, xf);

        // Asynchronous reset in the middle of a burst.
        cyc(4'b1111, 4'b0000, 1'b1, xf);
        cyc(4'b1111, 4'b0000, 1'b1, xf);
        @(posedge clk);
        #2;
        rst = 1'b0;
        req = 4'b0000;
        #1;
        chk("midrst_grant", 8'(grant), 8'h00);
        chk("midrst_sel", 8'(sel), 8'h00);
        chk("midrst_out_valid", 8'(out_valid), 8'h00);
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc(4'b1111, 4'b1111, 1'b1, xf);
        cyc(4'b1111, 4'b1111, 1'b1, xf);

        // Randomized traffic.
        rr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            cyc(rr, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, xf);
        end
        cyc(4'b0000, 4'b0000, 1'b0, xf);

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
